mem_block_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the shared 512x32 word memory.
- The memory moves one 16-word (512-bit) block per access: combinational read, write on the clock edge.
- Grants one requester at a time and drives the memory control, address and write-data pins for exactly one cycle.
- Captures read data into a register, range-checks addresses, and returns a one-cycle done pulse to the granted requester.

---
 rtl/mem_block_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_block_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_arbiter.sv
// rtl/mem_block_arbiter.sv - two-requester round-robin arbiter/sequencer for a 512x32 block memory
// Optional MEM_BLOCK_ARB_ALIGN_CHECK_EN: also reject block addresses not aligned to BLOCK_WORDS.
module mem_block_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 512,
  parameter int BLOCK_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'((2 ** ADDR_W) - BLOCK_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                win_q, win_d;
  logic                rr_last_q, rr_last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                addr_ok;
  logic                arb_en;
  logic                pick;

`ifdef MEM_BLOCK_ARB_ALIGN_CHECK_EN
  localparam int OFS_W = $clog2(BLOCK_WORDS);
  assign addr_ok = (addr_q <= MAX_ADDR) && (addr_q[OFS_W-1:0] == '0);
`else
  assign addr_ok = (addr_q <= MAX_ADDR);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      win_q     <= 1'b0;
      rr_last_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      win_q     <= win_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // The grant cycle is IDLE with gnt_q set; arbitration runs in a free IDLE cycle
  // or at the end of RESP, so a waiting request is granted as IDLE is re-entered.
  always_comb begin
    state_d   = state_q;
    gnt_d     = 1'b0;
    win_d     = win_q;
    rr_last_d = rr_last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err       = 1'b0;
    arb_en    = 1'b0;
    pick      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_q) state_d = S_ACCESS;
        else       arb_en  = 1'b1;
      end
      S_ACCESS: begin
        mem_read  = addr_ok & ~we_q;
        mem_write = addr_ok & we_q;
        err_d     = ~addr_ok;
        if (!addr_ok)  rdata_d = '0;
        else if (!we_q) rdata_d = mem_out_data;
        state_d   = S_RESP;
      end
      S_RESP: begin
        done0   = ~win_q;
        done1   = win_q;
        err     = err_q;
        arb_en  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (arb_en && (req0 || req1)) begin
      pick      = (req0 && req1) ? ~rr_last_q : req1;
      gnt_d     = 1'b1;
      win_d     = pick;
      rr_last_d = pick;
      we_d      = pick ? we1 : we0;
      addr_d    = pick ? addr1 : addr0;
      wdata_d   = pick ? wdata1 : wdata0;
    end
  end

  assign gnt0        = gnt_q & ~win_q;
  assign gnt1        = gnt_q & win_q;
  assign rdata       = rdata_q;
  assign mem_address = addr_q;
  assign mem_in_data = wdata_q;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// tb/tb_mem_block_arbiter.sv - scoreboard testbench for mem_block_arbiter
module tb_mem_block_arbiter;

  localparam logic [511:0] PAT_A = {16{32'hA5A5_1234}};
  localparam logic [511:0] PAT_B = {8{64'h0123_4567_89AB_CDEF}};
  localparam logic [511:0] PAT_C = {16{32'h5A5A_F00D}};

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, we0, we1;
  logic [8:0]   addr0, addr1;
  logic [511:0] wdata0, wdata1;
  logic         gnt0, gnt1, done0, done1, err;
  logic [511:0] rdata;
  logic         mem_read, mem_write;
  logic [8:0]   mem_address;
  logic [511:0] mem_in_data, mem_out_data;

  always #5 clk = ~clk;

  mem_block_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_in_data(mem_in_data),
    .mem_out_data(mem_out_data)
  );

  logic [31:0] mem [512] = '{default: '0};

  always_comb begin
    mem_out_data = '0;
    for (int i = 0; i < 16; i++)
      mem_out_data[i*32 +: 32] = mem[(int'(mem_address) + i) % 512];
  end

  always @(posedge clk) begin
    if (mem_write)
      for (int i = 0; i < 16; i++)
        mem[(int'(mem_address) + i) % 512] <= mem_in_data[i*32 +: 32];
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // kind: 0 = no memory access (error), 1 = read, 2 = write
  typedef struct {
    int           id;
    int           kind;
    logic [8:0]   addr;
    logic [511:0] wd;
    logic         err;
    logic         chk_rd;
    logic [511:0] rd;
    logic         b2b;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  bit   cur_v = 0;
  bit   mem_seen = 0;
  int   gnt_cyc = 0;
  int   done_cyc_last = -10;

  always @(negedge clk) begin
    if (rst) begin
      cur_v = 0;
    end else begin
      check_i("excl_gnt",  int'(gnt0 & gnt1), 0);
      check_i("excl_done", int'(done0 & done1), 0);
      check_i("excl_mem",  int'(mem_read & mem_write), 0);
      if (gnt0 | gnt1) begin
        if (expq.size() == 0) begin
          check_i("unexpected_gnt", 1, 0);
        end else begin
          cur      = expq.pop_front();
          cur_v    = 1;
          mem_seen = 0;
          gnt_cyc  = cyc;
          check_i("gnt_id", int'(gnt1), cur.id);
          if (cur.b2b) check_i("gnt_after_done", cyc, done_cyc_last + 1);
        end
      end
      if (mem_read | mem_write) begin
        if (!cur_v) begin
          check_i("unexpected_mem", 1, 0);
        end else begin
          mem_seen = 1;
          check_i("mem_latency", cyc - gnt_cyc, 1);
          check_i("mem_kind", int'({mem_write, mem_read}), cur.kind);
          check("mem_address", 512'(mem_address), 512'(cur.addr));
          if (mem_write) check("mem_in_data", mem_in_data, cur.wd);
        end
      end
      if (done0 | done1) begin
        if (!cur_v) begin
          check_i("unexpected_done", 1, 0);
        end else begin
          check_i("done_id", int'(done1), cur.id);
          check_i("done_latency", cyc - gnt_cyc, 2);
          check_i("err", int'(err), int'(cur.err));
          check_i("mem_accessed", int'(mem_seen), int'(cur.kind != 0));
          if (cur.chk_rd) check("rdata", rdata, cur.rd);
          done_cyc_last = cyc;
          cur_v = 0;
        end
      end
    end
  end

  function automatic exp_t mk(input int id, input logic we, input logic [8:0] a,
                              input logic [511:0] d, input logic e, input logic chk,
                              input logic [511:0] rd, input logic b2b);
    exp_t x;
    x.id = id; x.kind = e ? 0 : (we ? 2 : 1); x.addr = a; x.wd = d;
    x.err = e; x.chk_rd = chk; x.rd = rd; x.b2b = b2b;
    return x;
  endfunction

  task automatic raise(input int id, input logic we, input logic [8:0] a, input logic [511:0] d);
    if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop(input int id);
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
  endtask

  task automatic wait_gnt_drop(input int id);
    int n = 0;
    @(negedge clk);
    while (!(id == 0 ? gnt0 : gnt1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_i("gnt_timeout", n, 0);
    drop(id);
  endtask

  task automatic wait_any_gnt(output int id);
    int n = 0;
    @(negedge clk);
    while (!(gnt0 | gnt1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_i("gnt_timeout", n, 0);
    id = gnt1 ? 1 : 0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!(done0 | done1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_i("done_timeout", n, 0);
  endtask

  task automatic single(input int id, input logic we, input logic [8:0] a, input logic [511:0] d,
                        input logic e, input logic chk, input logic [511:0] rd);
    expq.push_back(mk(id, we, a, d, e, chk, rd, 1'b0));
    @(negedge clk);
    raise(id, we, a, d);
    wait_gnt_drop(id);
    wait_done();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int gid;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #1;
    check_i("rst_gnt",  int'({gnt0, gnt1}), 0);
    check_i("rst_done", int'({done0, done1, err}), 0);
    check_i("rst_mem",  int'({mem_read, mem_write}), 0);
    check("rst_rdata", rdata, '0);
    check("rst_mem_address", 512'(mem_address), '0);
    check("rst_mem_in_data", mem_in_data, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // write then read; rdata holds its previous value across writes
    single(0, 1'b1, 9'd32, PAT_A, 1'b0, 1'b1, '0);
    single(0, 1'b0, 9'd32, '0, 1'b0, 1'b1, PAT_A);
    single(0, 1'b1, 9'd64, PAT_B, 1'b0, 1'b1, PAT_A);

    // simultaneous requests from reset alternate 0,1,0,1
    do_reset();
    expq.push_back(mk(0, 1'b1, 9'd32, PAT_A, 1'b0, 1'b0, '0, 1'b0));
    expq.push_back(mk(1, 1'b1, 9'd64, PAT_B, 1'b0, 1'b0, '0, 1'b0));
    expq.push_back(mk(0, 1'b1, 9'd32, PAT_A, 1'b0, 1'b0, '0, 1'b0));
    expq.push_back(mk(1, 1'b1, 9'd64, PAT_B, 1'b0, 1'b0, '0, 1'b0));
    @(negedge clk);
    raise(0, 1'b1, 9'd32, PAT_A);
    raise(1, 1'b1, 9'd64, PAT_B);
    for (int k = 0; k < 4; k++) begin
      wait_any_gnt(gid);
      if (k == 2) drop(0);
      if (k == 3) drop(1);
    end
    wait_done();
    single(1, 1'b0, 9'd64, '0, 1'b0, 1'b1, PAT_B);

    // range boundary: 496 legal, 497 rejected with rdata forced to 0
    single(1, 1'b1, 9'd496, PAT_B, 1'b0, 1'b0, '0);
    single(1, 1'b0, 9'd496, '0, 1'b0, 1'b1, PAT_B);
    single(1, 1'b0, 9'd497, '0, 1'b1, 1'b1, '0);
    single(0, 1'b0, 9'd496, '0, 1'b0, 1'b1, PAT_B);
    single(0, 1'b1, 9'd511, PAT_C, 1'b1, 1'b1, '0);

    // unaligned address
`ifdef MEM_BLOCK_ARB_ALIGN_CHECK_EN
    single(0, 1'b1, 9'd200, PAT_C, 1'b1, 1'b1, '0);
    single(0, 1'b0, 9'd192, '0, 1'b0, 1'b1, '0);
`else
    single(0, 1'b1, 9'd200, PAT_C, 1'b0, 1'b0, '0);
    single(0, 1'b0, 9'd200, '0, 1'b0, 1'b1, PAT_C);
`endif

    // request raised mid-flight is granted the cycle after done
    expq.push_back(mk(0, 1'b1, 9'd128, PAT_C, 1'b0, 1'b0, '0, 1'b0));
    expq.push_back(mk(1, 1'b0, 9'd32, '0, 1'b0, 1'b1, PAT_A, 1'b1));
    @(negedge clk);
    raise(0, 1'b1, 9'd128, PAT_C);
    wait_gnt_drop(0);
    @(negedge clk);
    raise(1, 1'b0, 9'd32, '0);
    wait_gnt_drop(1);
    wait_done();

    // reset during ACCESS of a write abandons it
    expq.push_back(mk(0, 1'b1, 9'd256, PAT_A, 1'b0, 1'b0, '0, 1'b0));
    @(negedge clk);
    raise(0, 1'b1, 9'd256, PAT_A);
    wait_gnt_drop(0);
    @(posedge clk);
    #1;
    check_i("access_mem_write", int'(mem_write), 1);
    #1 rst = 1'b1;
    #1;
    check_i("rst_mem_write_drop", int'(mem_write), 0);
    check_i("rst_no_done", int'({done0, done1}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_i("abandoned_queue", expq.size(), 0);
    expq.push_back(mk(0, 1'b0, 9'd256, '0, 1'b0, 1'b1, '0, 1'b0));
    expq.push_back(mk(1, 1'b0, 9'd32, '0, 1'b0, 1'b1, PAT_A, 1'b0));
    @(negedge clk);
    raise(0, 1'b0, 9'd256, '0);
    raise(1, 1'b0, 9'd32, '0);
    for (int k = 0; k < 2; k++) begin
      wait_any_gnt(gid);
      drop(gid);
    end
    wait_done();

    repeat (4) @(negedge clk);
    check_i("queue_drained", expq.size(), 0);
    check_i("no_pending", int'(cur_v), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
